mycpu_mem_stage: RTL
====================

Name: mycpu_mem_stage

Overview:
- MEM pipeline stage sitting directly downstream of the EX stage and upstream of WB.
- Consumes the ALU result, the rt register content and the memory-op code produced by EX.
- Issues at most one request at a time on an SRAM-like data interface (req/addr_ok/data_ok), aligns and extends load data, and hands a registered result to WB over a valid/ready handshake.
- Detects misaligned accesses (AdEL/AdES) and supports flush with safe draining of in-flight requests.

Parameters:
- DATA_W, 32, datapath and address width.
- REG_AW, 5, destination register index width.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  kill the current instruction (exception/ERET from WB)
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  MEM accepts this cycle
- ex_alu_result  in  32  address for loads/stores, result otherwise
- ex_rt_cont  in  32  store data
- ex_dest  in  5  destination register
- ex_reg_we  in  1  register write enable
- ex_mem_op  in  4  memory op code (package encoding)
- data_req  out  1  data request
- data_wr  out  1  1 = store
- data_wstrb  out  4  byte enables
- data_addr  out  32  byte address
- data_wdata  out  32  replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response / write done
- data_rdata  in  32  load word
- wb_valid  out  1  result valid to WB
- wb_ready  in  1  WB accepts
- wb_result  out  32  result to WB
- wb_dest  out  5  destination register
- wb_reg_we  out  1  register write enable (forced 0 on exception)
- wb_adel  out  1  load address error
- wb_ades  out  1  store address error
- wb_badvaddr  out  32  faulting address

Behaviour:
- Reset (resetn=0, async): state=IDLE; all outputs 0 except ex_ready=1.
- FSM states:
  - IDLE: empty.
  - REQ: data_req high.
  - WAIT: awaiting data_ok.
  - HOLD: wb_valid high.
  - DRAIN: cancelled access awaiting data_ok.
- ex_ready = !flush && (state==IDLE || (state==HOLD && wb_ready)).
- Accept when ex_valid && ex_ready: register all ex_* fields.
  - MEM_NONE, reserved op, or misaligned → HOLD next cycle (latency 1).
  - Aligned load/store → REQ next cycle.
- Misalignment:
  - LH/LHU/SH: addr[0]≠0.
  - LW/SW: addr[1:0]≠0.
  - Result: wb_adel (loads) or wb_ades (stores) =1, wb_badvaddr=address, wb_reg_we=0, no data_req issued.
- REQ:
  - data_req, data_wr, data_wstrb, data_addr, data_wdata stay stable until data_addr_ok.
  - On data_addr_ok → WAIT.
  - data_data_ok is ignored before addr_ok.
- WAIT: on data_data_ok, capture the extended load data (stores: wb_result=address) → HOLD. Minimum load latency is accept+3 (REQ, addr_ok cycle, data_ok cycle, then wb_valid).
- HOLD:
  - wb_valid=1.
  - On wb_ready with a new accept → reload; without a new accept → IDLE.
- Store strobes and data:
  - SB: wstrb = 1<<addr[1:0], wdata = {4{rt[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{rt[15:0]}}.
  - SW: wstrb = 1111, wdata = rt.
  - Loads: wstrb = 0000.
- Load extraction:
  - LB/LBU: byte at addr[1:0], sign- or zero-extended.
  - LH/LHU: half at addr[1].
  - LW: full word.
- Flush:
  - In IDLE: nothing accepted that cycle.
  - In HOLD: wb_valid drops next cycle → IDLE.
  - In REQ: request is held until addr_ok (the request may not be withdrawn), then → DRAIN.
  - In WAIT → DRAIN.
  - DRAIN: discard data_ok → IDLE. No wb_valid is produced for a flushed instruction.
  - Flush and data_ok in the same WAIT cycle: the response is consumed and discarded → IDLE.
- Simultaneous addr_ok and data_ok in REQ: data_ok is ignored; the response must arrive in a later cycle.
- Reset mid-access: state returns to IDLE immediately; the memory side is reset by the same resetn.

Decomposition:
- Package mycpu_pkg:
  - MEM_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8 (9–15 reserved, treated as NONE).
  - FSM state typedef.
  - is_load/is_store helper functions.
- Sub-module mycpu_mem_align (combinational):
  - Strobe and replicated wdata generation.
  - Misalignment detection.
  - Load byte/half extraction and extension.

Test Plan:
- Non-memory op, alu_result=0x1234_5678, dest=3, wb_ready=1 → wb_valid next cycle, wb_result=0x1234_5678, wb_dest=3, no data_req.
- LB at 0x1000_0003, rdata=0x80AA_BBCC, addr_ok after 2 cycles, data_ok 1 cycle later → wb_result=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at 0x2002, rt=0xDEAD_BEEF → data_wstrb=1100, data_wdata=0xBEEF_BEEF, data_wr=1, req held stable until addr_ok.
- LW at 0x0000_0006 → wb_adel=1, wb_badvaddr=0x0000_0006, wb_reg_we=0, data_req never asserted.
- Flush during REQ before addr_ok → req held until addr_ok, following data_ok discarded, wb_valid stays 0, ex_ready returns 1 in IDLE.
- wb_ready=0 for 3 cycles in HOLD → wb_* stable, ex_ready=0; then wb_ready=1 with ex_valid=1 → back-to-back accept, no bubble.

Source files
------------

// File: rtl/mycpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mycpu_pkg
// Brief    : Shared memory-op encoding, MEM-stage state encoding and op helpers.
// Revision : 1.0
// ============================================================================
package mycpu_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LBU      = 4'd2,
        LH       = 4'd3,
        LHU      = 4'd4,
        LW       = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8
    } memOp_e;

    typedef logic [2:0] state_t;

    localparam state_t c_IDLE  = 3'd0;
    localparam state_t c_REQ   = 3'd1;
    localparam state_t c_WAIT  = 3'd2;
    localparam state_t c_HOLD  = 3'd3;
    localparam state_t c_DRAIN = 3'd4;

    // Codes 9..15 are reserved and fall out of both helpers as non-memory ops.
    function automatic logic is_load(input logic [3:0] op);
        return op inside {LB, LBU, LH, LHU, LW};
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op inside {SB, SH, SW};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mycpu_mem_align.sv
`default_nettype none
// ============================================================================
// Module   : mycpu_mem_align
// Brief    : Byte-lane logic: store strobes/replication, misalignment check,
//            load extraction and extension.
// Revision : 1.0
// ============================================================================
module mycpu_mem_align
    import mycpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        i_exOp,
    input  logic [1:0]        i_exAddrLo,
    input  logic [3:0]        i_op,
    input  logic [1:0]        i_addrLo,
    input  logic [DATA_W-1:0] i_rt,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_exMisalign,
    output logic [3:0]        o_wstrb,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_loadData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Checked on the incoming EX op so a faulting access never reaches REQ.
    always_comb begin
        o_exMisalign = 1'b0;
        case (i_exOp)
            LH, LHU, SH: o_exMisalign = i_exAddrLo[0];
            LW, SW:      o_exMisalign = |i_exAddrLo;
            default:     o_exMisalign = 1'b0;
        endcase
    end

    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = i_rt;
        case (i_op)
            SB: begin
                o_wstrb = 4'b0001 << i_addrLo;
                o_wdata = {4{i_rt[7:0]}};
            end
            SH: begin
                o_wstrb = i_addrLo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_rt[15:0]}};
            end
            SW:      o_wstrb = 4'b1111;
            default: o_wstrb = 4'b0000;
        endcase
    end

    always_comb begin
        case (i_addrLo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addrLo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_loadData = i_rdata;
        case (i_op)
            LB:      o_loadData = {{24{w_byte[7]}}, w_byte};
            LBU:     o_loadData = {24'd0, w_byte};
            LH:      o_loadData = {{16{w_half[15]}}, w_half};
            LHU:     o_loadData = {16'd0, w_half};
            default: o_loadData = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mycpu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mycpu_mem_stage
// Brief    : MEM pipeline stage: single-outstanding SRAM-like data access,
//            address-error detection, flush draining, valid/ready to WB.
// Revision : 1.0
// ============================================================================
module mycpu_mem_stage
    import mycpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_rt_cont,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_reg_we,
    input  logic [3:0]        ex_mem_op,
    output logic              data_req,
    output logic              data_wr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_result,
    output logic [REG_AW-1:0] wb_dest,
    output logic              wb_reg_we,
    output logic              wb_adel,
    output logic              wb_ades,
    output logic [DATA_W-1:0] wb_badvaddr
);

    state_t              r_state;
    logic                r_kill;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_rt;
    logic [3:0]          r_op;
    logic [DATA_W-1:0]   r_wbResult;
    logic [REG_AW-1:0]   r_wbDest;
    logic                r_wbRegWe;
    logic                r_adel;
    logic                r_ades;
    logic [DATA_W-1:0]   r_badVaddr;

    logic                w_accept;
    logic                w_exIsMem;
    logic                w_exMisalign;
    logic [3:0]          w_wstrb;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_loadData;

    mycpu_mem_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_exOp       (ex_mem_op),
        .i_exAddrLo   (ex_alu_result[1:0]),
        .i_op         (r_op),
        .i_addrLo     (r_addr[1:0]),
        .i_rt         (r_rt),
        .i_rdata      (data_rdata),
        .o_exMisalign (w_exMisalign),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_loadData   (w_loadData)
    );

    assign ex_ready  = !flush && ((r_state == c_IDLE) || ((r_state == c_HOLD) && wb_ready));
    assign w_accept  = ex_valid && ex_ready;
    assign w_exIsMem = is_load(ex_mem_op) || is_store(ex_mem_op);

    assign data_req    = (r_state == c_REQ);
    assign data_wr     = data_req && is_store(r_op);
    assign data_wstrb  = w_wstrb;
    assign data_addr   = r_addr;
    assign data_wdata  = w_wdata;

    assign wb_valid    = (r_state == c_HOLD);
    assign wb_result   = r_wbResult;
    assign wb_dest     = r_wbDest;
    assign wb_reg_we   = r_wbRegWe;
    assign wb_adel     = r_adel;
    assign wb_ades     = r_ades;
    assign wb_badvaddr = r_badVaddr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= c_IDLE;
            r_kill     <= 1'b0;
            r_addr     <= '0;
            r_rt       <= '0;
            r_op       <= 4'd0;
            r_wbResult <= '0;
            r_wbDest   <= '0;
            r_wbRegWe  <= 1'b0;
            r_adel     <= 1'b0;
            r_ades     <= 1'b0;
            r_badVaddr <= '0;
        end else begin
            case (r_state)
                c_IDLE: r_state <= c_IDLE;
                // A posted request cannot be withdrawn; remember the flush until it is taken.
                c_REQ: begin
                    if (data_addr_ok) begin
                        r_state <= (flush || r_kill) ? c_DRAIN : c_WAIT;
                        r_kill  <= 1'b0;
                    end else if (flush) begin
                        r_kill  <= 1'b1;
                    end
                end
                c_WAIT: begin
                    if (flush) begin
                        r_state <= data_data_ok ? c_IDLE : c_DRAIN;
                    end else if (data_data_ok) begin
                        r_state    <= c_HOLD;
                        r_wbResult <= is_load(r_op) ? w_loadData : r_addr;
                    end
                end
                c_HOLD: begin
                    if (flush || wb_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                c_DRAIN: begin
                    if (data_data_ok) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            // Accept overrides the HOLD->IDLE exit so back-to-back results have no bubble.
            if (w_accept) begin
                r_addr     <= ex_alu_result;
                r_rt       <= ex_rt_cont;
                r_op       <= ex_mem_op;
                r_kill     <= 1'b0;
                r_wbResult <= ex_alu_result;
                r_wbDest   <= ex_dest;
                r_wbRegWe  <= ex_reg_we && !w_exMisalign;
                r_adel     <= w_exMisalign && is_load(ex_mem_op);
                r_ades     <= w_exMisalign && is_store(ex_mem_op);
                r_badVaddr <= w_exMisalign ? ex_alu_result : '0;
                r_state    <= (w_exIsMem && !w_exMisalign) ? c_REQ : c_HOLD;
            end
        end
    end

endmodule
`default_nettype wire
